pci_fcfs_arbiter: RTL and testbench

PCI_FCFS_ARBITER -- requirements
Module: pci_fcfs_arbiter

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_idx_fifo.sv | 45 ++++
 rtl/pci_fcfs_arbiter.sv | 124 ++++++++++++
 tb/tb_pci_fcfs_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and the controller state type for the FCFS PCI arbiter.
package arb_pkg;
  localparam int NUM_MASTERS = 8;
  localparam int IDX_W       = 3;
  localparam int GNT_TIMEOUT = 16;
  localparam int FIFO_DEPTH  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arb_idx_fifo.sv
// Circular FIFO of master indices; 3-bit pointers wrap naturally from 7 to 0.
module arb_idx_fifo
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] din,
  input  logic             pop,
  output logic [IDX_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [IDX_W-1:0] rd_ptr, wr_ptr;
  logic [IDX_W:0]   count;
  logic             do_push, do_pop;

  assign full    = (count == (IDX_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pci_fcfs_arbiter.sv
// First-come-first-served PCI bus arbiter with idle-grant timeout.
// Define ARB_PARK_EN to park the grant on the last owner while idle.
module pci_fcfs_arbiter #(
  parameter int NUM_MASTERS = arb_pkg::NUM_MASTERS,
  parameter int GNT_TIMEOUT = arb_pkg::GNT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt,
  input  logic                   frame,
  input  logic                   irdy,
  input  logic                   trdy,
  output logic [2:0]             owner,
  output logic                   owner_vld
);
  import arb_pkg::*;

  localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);

  arb_state_t             state, state_d;
  logic [NUM_MASTERS-1:0] req_q, queued, queued_d, elig, owner_oh, gnt_d;
  logic [IDX_W-1:0]       owner_d, push_idx, head;
  logic                   owner_vld_d, push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]       tmo_cnt, tmo_cnt_d;

  assign owner_oh = NUM_MASTERS'(1) << owner;

  // One enqueue per cycle, lowest eligible index wins; the active owner is
  // excluded so a still-requesting owner re-enters at the tail once released.
  always_comb begin
    elig     = ~req & ~queued & (owner_vld ? ~owner_oh : '1);
    push     = 1'b0;
    push_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        push     = 1'b1;
        push_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    owner_vld_d = owner_vld;
    tmo_cnt_d   = tmo_cnt;
    pop         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          owner_d     = head;
          owner_vld_d = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = GRANTED;
        end
      end
      GRANTED: begin
        if (!frame) begin
          state_d = BUSY;
        end else if (req_q[owner] || tmo_cnt == CNT_W'(GNT_TIMEOUT - 1)) begin
          state_d     = IDLE;
          owner_vld_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      BUSY: begin
        if (frame && !irdy && !trdy) begin
          state_d     = IDLE;
          owner_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_PARK_EN
    gnt_d = ~(NUM_MASTERS'(1) << owner_d);
`else
    gnt_d = owner_vld_d ? ~(NUM_MASTERS'(1) << owner_d) : '1;
`endif
  end

  always_comb begin
    queued_d = queued;
    if (push) queued_d[push_idx] = 1'b1;
    if (pop)  queued_d[head]     = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      queued    <= '0;
      gnt       <= '1;
      owner     <= '0;
      owner_vld <= 1'b0;
      tmo_cnt   <= '0;
      req_q     <= '1;
    end else begin
      state     <= state_d;
      queued    <= queued_d;
      gnt       <= gnt_d;
      owner     <= owner_d;
      owner_vld <= owner_vld_d;
      tmo_cnt   <= tmo_cnt_d;
      req_q     <= req;
    end
  end

  arb_idx_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_idx),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Each master holds at most one slot, so a push into a full FIFO means
  // the queued bookkeeping has gone wrong.
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
endmodule

// File: tb/tb_pci_fcfs_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random vs queue model.
module tb_pci_fcfs_arbiter;
  localparam int NM  = 8;
  localparam int TMO = 16;
`ifdef ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       frame = 1'b1, irdy = 1'b1, trdy = 1'b1;
  logic [7:0] gnt;
  logic [2:0] owner;
  logic       owner_vld;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  pci_fcfs_arbiter #(.NUM_MASTERS(NM), .GNT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .frame(frame),
    .irdy(irdy), .trdy(trdy), .owner(owner), .owner_vld(owner_vld)
  );

  // Reference model: waiting line as a queue, owner holds grant or not.
  int         q[$];
  bit         hold, txn;
  int         mown, wcnt;
  logic [7:0] mreq_q = 8'hFF;
  logic [7:0] gexp = 8'hFF;

  function automatic bit in_q(int i);
    foreach (q[k]) if (q[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int nxt;
    if (rst) begin
      q.delete(); hold = 0; txn = 0; mown = 0; wcnt = 0;
      mreq_q = 8'hFF; gexp = 8'hFF;
      return;
    end
    nxt = -1;
    for (int i = NM - 1; i >= 0; i--)
      if (!req[i] && !in_q(i) && !(hold && mown == i)) nxt = i;
    if (!hold) begin
      if (q.size() > 0) begin
        mown = q.pop_front(); hold = 1; txn = 0; wcnt = 0;
      end
    end else if (!txn) begin
      if (!frame) txn = 1;
      else if (mreq_q[mown]) hold = 0;
      else begin
        wcnt++;
        if (wcnt == TMO) hold = 0;
      end
    end else if (frame && !irdy && !trdy) hold = 0;
    if (nxt >= 0) q.push_back(nxt);
    mreq_q = req;
    gexp = (hold || PARK) ? ~(8'h01 << mown) : 8'hFF;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] eg, logic ev, logic [2:0] eo);
    total++;
    if (gnt !== eg || owner_vld !== ev || owner !== eo) begin
      bad++;
      $display("FAIL %s: got gnt=%h vld=%b owner=%0d, want gnt=%h vld=%b owner=%0d",
               name, gnt, owner_vld, owner, eg, ev, eo);
    end
  endtask

  function automatic logic [7:0] idl(int o);
    return PARK ? ~(8'h01 << o) : 8'hFF;
  endfunction

  typedef struct {
    logic       r;
    logic [7:0] rq;
    logic [2:0] fit;
    logic [7:0] g;
    logic       v;
    logic [2:0] o;
  } vec_t;

  function automatic vec_t v(logic r, logic [7:0] rq, logic [2:0] fit,
                             logic [7:0] g, logic vl, logic [2:0] o);
    vec_t x;
    x.r = r; x.rq = rq; x.fit = fit; x.g = g; x.v = vl; x.o = o;
    return x;
  endfunction

  vec_t tbl[18];

  initial begin
    int n;
    // {frame,irdy,trdy} in fit; expected outputs seen after the edge
    tbl[0]  = v(1'b1, 8'hFF, 3'b111, 8'hFF,   1'b0, 3'd0);
    tbl[1]  = v(1'b0, 8'hFF, 3'b111, idl(0),  1'b0, 3'd0);
    tbl[2]  = v(1'b0, 8'hFE, 3'b111, idl(0),  1'b0, 3'd0);
    tbl[3]  = v(1'b0, 8'hFE, 3'b111, 8'hFE,   1'b1, 3'd0);
    tbl[4]  = v(1'b0, 8'hFE, 3'b011, 8'hFE,   1'b1, 3'd0);
    tbl[5]  = v(1'b0, 8'hFE, 3'b000, 8'hFE,   1'b1, 3'd0);
    tbl[6]  = v(1'b0, 8'hFF, 3'b100, idl(0),  1'b0, 3'd0);
    tbl[7]  = v(1'b0, 8'hFF, 3'b111, idl(0),  1'b0, 3'd0);
    tbl[8]  = v(1'b0, 8'hF6, 3'b111, idl(0),  1'b0, 3'd0);
    tbl[9]  = v(1'b0, 8'hF6, 3'b111, 8'hFE,   1'b1, 3'd0);
    tbl[10] = v(1'b0, 8'hF6, 3'b011, 8'hFE,   1'b1, 3'd0);
    tbl[11] = v(1'b0, 8'hF6, 3'b100, idl(0),  1'b0, 3'd0);
    tbl[12] = v(1'b0, 8'hF6, 3'b111, 8'hF7,   1'b1, 3'd3);
    tbl[13] = v(1'b0, 8'hF7, 3'b011, 8'hF7,   1'b1, 3'd3);
    tbl[14] = v(1'b0, 8'hFF, 3'b100, idl(3),  1'b0, 3'd3);
    tbl[15] = v(1'b0, 8'hFF, 3'b111, 8'hFE,   1'b1, 3'd0);
    tbl[16] = v(1'b0, 8'hFF, 3'b111, idl(0),  1'b0, 3'd0);
    tbl[17] = v(1'b0, 8'hFF, 3'b111, idl(0),  1'b0, 3'd0);

    foreach (tbl[k]) begin
      rst = tbl[k].r; req = tbl[k].rq; {frame, irdy, trdy} = tbl[k].fit;
      tick();
      check($sformatf("vec%0d", k), tbl[k].g, tbl[k].v, tbl[k].o);
    end

    // Arrival order beats index: 5 owns the bus, then 3 and later 1 queue up.
    req = 8'hDF; tick(); tick();
    check("ord_own5", 8'hDF, 1'b1, 3'd5);
    frame = 1'b0; tick();
    req = 8'hD7; tick(); tick();
    req = 8'hD5; tick(); tick();
    {frame, irdy, trdy} = 3'b100; req = 8'hF5; tick();
    check("ord_rel5", idl(5), 1'b0, 3'd5);
    {frame, irdy, trdy} = 3'b111; tick();
    check("ord_first3", 8'hF7, 1'b1, 3'd3);
    req = 8'hFD; tick(); tick();
    check("ord_drop3", idl(3), 1'b0, 3'd3);
    tick();
    check("ord_second1", 8'hFD, 1'b1, 3'd1);
    req = 8'hFF; tick(); tick();
    check("ord_drop1", idl(1), 1'b0, 3'd1);

    // Idle grant to master 2 is revoked after exactly TMO cycles.
    req = 8'hFB;
    for (int w = 0; w < 10 && !owner_vld; w++) tick();
    check("tmo_grant", 8'hFB, 1'b1, 3'd2);
    n = 1;
    for (int w = 0; w < 40 && owner_vld; w++) begin
      tick();
      if (owner_vld) n++;
    end
    total++;
    if (n != TMO) begin
      bad++;
      $display("FAIL tmo_len: got %0d grant cycles, want %0d", n, TMO);
    end
    check("tmo_rel", idl(2), 1'b0, 3'd2);
    req = 8'hFF; tick(); tick();
    check("tmo_idle", idl(2), 1'b0, 3'd2);

    // Reset during a transaction drops the grant and the pending queue.
    req = 8'hEF; tick(); tick();
    check("rst_own4", 8'hEF, 1'b1, 3'd4);
    frame = 1'b0; req = 8'hAF; tick(); tick();
    rst = 1'b1; tick();
    check("rst_busy", 8'hFF, 1'b0, 3'd0);
    rst = 1'b0; req = 8'hFF; frame = 1'b1; tick(); tick(); tick();
    check("rst_fifo_empty", idl(0), 1'b0, 3'd0);

    // All masters at once: served strictly in index order.
    req = 8'h00;
    for (int k = 0; k < NM; k++) begin
      for (int w = 0; w < 20 && !owner_vld; w++) tick();
      check($sformatf("simul%0d", k), ~(8'h01 << k), 1'b1, 3'(k));
      frame = 1'b0; tick();
      {frame, irdy, trdy} = 3'b100; req[k] = 1'b1; tick();
      {frame, irdy, trdy} = 3'b111;
    end
    tick();
    check("simul_done", idl(7), 1'b0, 3'd7);

`ifdef ARB_PARK_EN
    req = 8'hDF; tick(); tick();
    frame = 1'b0; tick();
    {frame, irdy, trdy} = 3'b100; req = 8'hFF; tick();
    {frame, irdy, trdy} = 3'b111; tick(); tick();
    check("park_hold", 8'hDF, 1'b0, 3'd5);
    req = 8'hFE; tick(); tick();
    check("park_move", 8'hFE, 1'b1, 3'd0);
    req = 8'hFF; tick(); tick();
`endif

    // Random traffic against the queue model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NM; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ((c % 500) >= 440) begin
        frame = 1'b1; irdy = 1'b1; trdy = 1'b1;
      end else begin
        frame = ($urandom_range(0, 3) != 0);
        irdy  = $urandom_range(0, 1) != 0;
        trdy  = $urandom_range(0, 1) != 0;
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
      check("rand", gexp, hold, 3'(mown));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
